// File: rtl/program_loader_ctrl_pkg.sv
// Shared types for the program loader: FSM state encoding, length width, state-class helpers.
// CSUM exists only when LOADER_CHECKSUM_EN is defined.
package program_loader_ctrl_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    CSUM  = 3'd5,
`endif
    RUN   = 3'd6,
    ERR   = 3'd7
  } state_t;

  // States that present byte_ready to the stream source.
  function automatic logic is_rx_state(input state_t s);
`ifdef LOADER_CHECKSUM_EN
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
`else
    return (s == LEN0) || (s == LEN1) || (s == DATA);
`endif
  endfunction

  function automatic logic is_busy_state(input state_t s);
    return is_rx_state(s) || (s == WRITE);
  endfunction

endpackage

// File: rtl/program_loader_ctrl_byte_word_packer.sv
// byte_word_packer: collects 4 stream bytes into a little-endian word.
// Latency: word presents the completed value combinationally on the 4th accepted byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0]  cnt;
  logic [31:0] word_q;

  // The incoming byte is merged in so the caller can capture the full word on the last byte.
  always_comb begin
    word = word_q;
    word[{cnt, 3'b000} +: 8] = byte_in;
  end

  assign last = (cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 2'd0;
      word_q <= 32'd0;
    end else if (clear) begin
      cnt    <= 2'd0;
      word_q <= 32'd0;
    end else if (take) begin
      cnt    <= cnt + 2'd1;
      word_q <= word;
    end
  end

endmodule

// File: rtl/program_loader_ctrl.sv
// Streams a length-prefixed byte image into instruction memory, then releases the core.
// Latency: one WRITE cycle per word, no bytes taken then. Backpressure: byte_ready low outside LEN0/LEN1/DATA/CSUM. Optional checksum: LOADER_CHECKSUM_EN.
module program_loader_ctrl
  import program_loader_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        load_enable,
  output logic [31:0] load_address,
  output logic [31:0] load_data,
  output logic        fetch_enable,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t           state, state_nxt;
  logic             take, start_accept, pack_take, pack_last;
  logic [31:0]      pack_word;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len_rx, word_cnt, idx, idx_inc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign take         = byte_valid & byte_ready;
  assign start_accept = start & ((state == IDLE) || (state == RUN) || (state == ERR));
  assign pack_take    = take & (state == DATA);
  assign len_rx       = {byte_in, len_lo};
  assign idx_inc      = idx + LEN_W'(1);

  byte_word_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_accept),
    .take    (pack_take),
    .byte_in (byte_in),
    .word    (pack_word),
    .last    (pack_last)
  );

  always_comb begin
    state_nxt = state;
    if (start_accept) begin
      state_nxt = LEN0;
    end else begin
      case (state)
        LEN0:  if (take) state_nxt = LEN1;
        LEN1:  if (take) state_nxt = ((len_rx == '0) || (len_rx > LEN_W'(MAX_WORDS))) ? ERR : DATA;
        DATA:  if (pack_take && pack_last) state_nxt = WRITE;
`ifdef LOADER_CHECKSUM_EN
        WRITE: state_nxt = (idx_inc == word_cnt) ? CSUM : DATA;
        CSUM:  if (take) state_nxt = (byte_in == csum) ? RUN : ERR;
`else
        WRITE: state_nxt = (idx_inc == word_cnt) ? RUN : DATA;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      load_enable  <= 1'b0;
      load_address <= 32'd0;
      load_data    <= 32'd0;
      fetch_enable <= 1'b0;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      len_lo       <= 8'd0;
      word_cnt     <= '0;
      idx          <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state        <= state_nxt;
      byte_ready   <= is_rx_state(state_nxt);
      busy         <= is_busy_state(state_nxt);
      load_enable  <= (state_nxt == WRITE);
      fetch_enable <= (state_nxt == RUN);
      done         <= (state_nxt == RUN);
      core_hold    <= (state_nxt != RUN);
      error        <= (state_nxt == ERR);
      if (start_accept) begin
        idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum <= 8'd0;
`endif
      end else begin
        case (state)
          LEN0: if (take) len_lo <= byte_in;
          LEN1: if (take) word_cnt <= len_rx;
          DATA: begin
            if (pack_take) begin
`ifdef LOADER_CHECKSUM_EN
              csum <= csum ^ byte_in;
`endif
              if (pack_last) begin
                load_address <= BASE_ADDR + 32'(ADDR_STEP) * 32'(idx);
                load_data    <= pack_word;
              end
            end
          end
          WRITE: idx <= idx_inc;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Randomized bench for program_loader_ctrl against a per-image reference model of expected writes/outcome.
module tb_program_loader_ctrl;

  localparam logic [31:0] TB_BASE = 32'h0000_0100;
  localparam int unsigned TB_STEP = 4;
  localparam int          TB_MAX  = 8;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid, byte_ready;
  logic [7:0]  byte_in;
  logic        load_enable, fetch_enable, core_hold, busy, done, error;
  logic [31:0] load_address, load_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] img[$];
`ifdef LOADER_CHECKSUM_EN
  bit          csum_bad = 1'b0;
`endif

  always #5 clk = ~clk;

  program_loader_ctrl #(
    .BASE_ADDR (TB_BASE),
    .ADDR_STEP (TB_STEP),
    .MAX_WORDS (TB_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .load_enable  (load_enable),
    .load_address (load_address),
    .load_data    (load_data),
    .fetch_enable (fetch_enable),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Capture every memory write; the stream must be stalled on write cycles.
  always @(negedge clk) begin
    if (reset && load_enable) begin
      wr_addr_q.push_back(load_address);
      wr_data_q.push_back(load_data);
      check("write_ready_low", 32'(byte_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while ($urandom_range(0, 2) == 0) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) begin
      check("handshake_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_fetch_off", 32'(fetch_enable), 32'd0);
    check("start_done_off", 32'(done), 32'd0);
  endtask

  // Model: a length in 1..MAX writes every word at BASE+STEP*i; the image then runs unless its checksum is wrong.
  task automatic run_image(input int n);
    bit         valid_n, exp_ok;
    logic [7:0] x;
    int         exp_writes, guard;
    valid_n = (n >= 1) && (n <= TB_MAX);
    exp_ok  = valid_n;
    while (img.size() < n) img.push_back($urandom);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    x = 8'd0;
    if (valid_n) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) begin
          logic [31:0] w;
          w = img[i];
          send_byte(w[8*k +: 8]);
          x = x ^ w[8*k +: 8];
        end
`ifdef LOADER_CHECKSUM_EN
      send_byte(csum_bad ? (x ^ 8'h01) : x);
      exp_ok = !csum_bad;
`endif
    end
    guard = 0;
    while (!done && !error && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    exp_writes = valid_n ? n : 0;
    check("outcome_done", 32'(done), 32'(exp_ok));
    check("outcome_fetch", 32'(fetch_enable), 32'(exp_ok));
    check("outcome_hold", 32'(core_hold), 32'(!exp_ok));
    check("outcome_error", 32'(error), 32'(!exp_ok));
    check("outcome_busy", 32'(busy), 32'd0);
    check("outcome_ready", 32'(byte_ready), 32'd0);
    check("write_count", 32'(wr_addr_q.size()), 32'(exp_writes));
    for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
      check("write_addr", wr_addr_q[i], TB_BASE + TB_STEP * 32'(i));
      check("write_data", wr_data_q[i], img[i]);
    end
    if (valid_n) begin
      check("hold_addr", load_address, TB_BASE + TB_STEP * 32'(n - 1));
      check("hold_data", load_data, img[n-1]);
    end
    img.delete();
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_load_en", 32'(load_enable), 32'd0);
    check("rst_addr", load_address, 32'd0);
    check("rst_data", load_data, 32'd0);
    check("rst_fetch", 32'(fetch_enable), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    img.push_back(32'h0000_0013);
    run_image(1);
    run_image(3);
    run_image(0);
    run_image(TB_MAX + 1);
    run_image(257);
    run_image(TB_MAX);

`ifdef LOADER_CHECKSUM_EN
    csum_bad = 1'b0;
    img.push_back(32'hDDCC_BBAA);
    run_image(1);
    csum_bad = 1'b1;
    img.push_back(32'hDDCC_BBAA);
    run_image(1);
    csum_bad = 1'b0;
`endif

    // Reset lands while the third data byte is on the bus.
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'd3);
    send_byte(8'd0);
    send_byte(img[0][7:0]);
    send_byte(img[0][15:8]);
    byte_in    = img[0][23:16];
    byte_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_ready", 32'(byte_ready), 32'd0);
    check("async_load_en", 32'(load_enable), 32'd0);
    check("async_addr", load_address, 32'd0);
    check("async_data", load_data, 32'd0);
    check("async_fetch", 32'(fetch_enable), 32'd0);
    check("async_core_hold", 32'(core_hold), 32'd1);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_error", 32'(error), 32'd0);
    byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_image(3);

    for (int r = 0; r < 8; r++) begin
`ifdef LOADER_CHECKSUM_EN
      csum_bad = ($urandom_range(0, 3) == 0);
`endif
      run_image(int'($urandom_range(0, TB_MAX + 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader_ctrl.md
PROGRAM_LOADER_CTRL -- requirements
Module: program_loader_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: instruction-memory address of the first loaded word.
REQ-002 Parameter ADDR_STEP, default 4: address increment per loaded word.
REQ-003 Parameter MAX_WORDS, default 256, range 1..65535: largest accepted image length in words.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin an image load.
REQ-007 byte_in  input  8  image stream byte.
REQ-008 byte_valid  input  1  byte_in is valid.
REQ-009 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-010 load_enable  output  1  instruction-memory write strobe.
REQ-011 load_address  output  32  instruction-memory write address.
REQ-012 load_data  output  32  instruction-memory write word.
REQ-013 fetch_enable  output  1  permits PC advance and fetch.
REQ-014 core_hold  output  1  holds the PC at its reset value while asserted.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  image loaded and core running.
REQ-017 error  output  1  load aborted.

Function
REQ-018 The block SHALL complete a byte transfer only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 The FSM SHALL have states IDLE, LEN0, LEN1, DATA, WRITE, CSUM, RUN and ERR.
REQ-020 On start=1 in IDLE, RUN or ERR, the next state SHALL be LEN0, clearing the word index, byte counter and checksum; start SHALL be ignored in every other state.
REQ-021 LEN0 and LEN1 SHALL each accept one byte, forming word count N little-endian (LEN0 supplies the LSB).
REQ-022 After the LEN1 byte, N=0 or N>MAX_WORDS SHALL go to ERR; otherwise the next state SHALL be DATA.
REQ-023 DATA SHALL accept 4 bytes little-endian, first byte to bits [7:0], then enter WRITE.
REQ-024 WRITE SHALL last exactly one cycle: load_enable=1, load_address=BASE_ADDR+ADDR_STEP*idx (32-bit, wraps modulo 2^32), load_data=assembled word, byte_ready=0; idx then increments.
REQ-025 After WRITE, idx<N SHALL return to DATA; idx==N SHALL go to CSUM when the checksum is compiled in, otherwise to RUN.
REQ-026 byte_ready SHALL be 1 only in LEN0, LEN1, DATA and CSUM.
REQ-027 In RUN, outputs SHALL be fetch_enable=1, done=1, core_hold=0; in every other state fetch_enable=0, done=0, core_hold=1.
REQ-028 busy SHALL be 1 in LEN0, LEN1, DATA, WRITE and CSUM; error SHALL be 1 only in ERR.
REQ-029 load_enable SHALL never be asserted outside WRITE; load_address and load_data SHALL hold their last values outside WRITE.
REQ-030 A restart from RUN SHALL drop fetch_enable on the first cycle in LEN0.

Reset
REQ-031 reset=0 SHALL force IDLE immediately, including mid-load.
REQ-032 Reset SHALL set every output to 0 except core_hold=1, and clear all counters and the checksum.

Configuration
REQ-033 With LOADER_CHECKSUM_EN defined, CSUM SHALL accept one byte: a match with the XOR of all data bytes SHALL go to RUN, a mismatch to ERR.
REQ-034 With LOADER_CHECKSUM_EN undefined, the CSUM state and XOR logic SHALL be absent, and the image SHALL carry no trailing byte.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the 16-bit length width constant.
REQ-036 One sub-module, byte_word_packer, SHALL hold the 4-byte little-endian assembly register and counter.

Verification
REQ-037 Stream 01 00 13 00 00 00 after start (checksum off) -> one load_enable with address 0x0, data 0x00000013; then fetch_enable=1, done=1.
REQ-038 Stream N=3 with BASE_ADDR=0x100 -> exactly three writes at 0x100, 0x104, 0x108; byte_ready=0 on each WRITE cycle.
REQ-039 Length bytes 00 00, and separately N=MAX_WORDS+1 -> ERR with error=1, no load_enable, fetch_enable=0; a later start plus a valid image -> RUN.
REQ-040 Macro on, N=1, data AA BB CC DD, checksum byte 0x00 -> RUN; checksum byte 0x01 -> ERR, with the word already written to 0xDDCCBBAA.
REQ-041 reset low during the third DATA byte -> outputs immediately take reset values; a restart loads correctly from idx 0.
REQ-042 byte_valid toggled randomly through a load -> only handshaked bytes are consumed and the written words are unchanged.
